// File: rtl/race_countdown.sv
// race_countdown: N..1-GO pre-race countdown responder with a four-phase start/done handshake.
module race_countdown #(
  parameter int unsigned TICKS_PER_STEP = 65_000_000,
  parameter int unsigned STEPS          = 3,
  parameter int unsigned GO_TICKS       = 32_500_000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  output logic [3:0] digit,
  output logic       go,
  output logic       active,
  output logic       done
);
  localparam int unsigned MAX_T = (TICKS_PER_STEP > GO_TICKS) ? TICKS_PER_STEP : GO_TICKS;
  localparam int CW = $clog2(MAX_T);
  localparam logic [CW-1:0] STEP_LAST = CW'(TICKS_PER_STEP - 1);
  localparam logic [CW-1:0] GO_LAST   = CW'(GO_TICKS - 1);
  typedef enum logic [1:0] {IDLE, COUNT, GO, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    digit_q, digit_d;
  logic          go_q, go_d, active_q, active_d, done_q, done_d;
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      digit_q  <= '0;
      go_q     <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      go_q     <= go_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digit_d  = digit_q;
    go_d     = go_q;
    active_d = active_q;
    done_d   = done_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = COUNT;
        digit_d  = 4'(STEPS);
        cnt_d    = '0;
        active_d = 1'b1;
      end
      COUNT: if (!hold) begin
        if (cnt_q == STEP_LAST) begin
          cnt_d = '0;
          if (digit_q > 4'd1) digit_d = digit_q - 4'd1;
          else begin
            state_d = GO;
            digit_d = '0;
            go_d    = 1'b1;
          end
        end else cnt_d = cnt_q + CW'(1);
      end
      GO: if (!hold) begin
        if (cnt_q == GO_LAST) begin
          state_d  = DONE;
          cnt_d    = '0;
          go_d     = 1'b0;
          active_d = 1'b0;
          done_d   = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      DONE: if (!start) begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Dropping start mid-run wins over hold and over a coincident tick expiry
    if (!start && (state_q == COUNT || state_q == GO)) begin
      state_d  = IDLE;
      cnt_d    = '0;
      digit_d  = '0;
      go_d     = 1'b0;
      active_d = 1'b0;
      done_d   = 1'b0;
    end
  end
  assign digit  = digit_q;
  assign go     = go_q;
  assign active = active_q;
  assign done   = done_q;
endmodule

// File: tb/tb_race_countdown.sv
// tb_race_countdown: directed checks of race_countdown, run on two parameter sets.
module tb_race_countdown;
  logic       pclk = 1'b0, rst = 1'b1;
  logic       start_a = 1'b0, hold_a = 1'b0, start_b = 1'b0, hold_b = 1'b0;
  logic [3:0] digit_a, digit_b;
  logic       go_a, active_a, done_a, go_b, active_b, done_b;
  int         n_chk = 0, n_pass = 0;
  always #5 pclk = ~pclk;
  race_countdown #(.TICKS_PER_STEP(4), .STEPS(3), .GO_TICKS(2)) dut_a (
    .pclk(pclk), .rst(rst), .start(start_a), .hold(hold_a),
    .digit(digit_a), .go(go_a), .active(active_a), .done(done_a));
  race_countdown #(.TICKS_PER_STEP(2), .STEPS(1), .GO_TICKS(1)) dut_b (
    .pclk(pclk), .rst(rst), .start(start_b), .hold(hold_b),
    .digit(digit_b), .go(go_b), .active(active_b), .done(done_b));
  wire [6:0] out_a = {digit_a, go_a, active_a, done_a};
  wire [6:0] out_b = {digit_b, go_b, active_b, done_b};
  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%b exp=%b ({digit,go,active,done})", tag, got, exp);
  endtask
  task automatic step();
    @(posedge pclk);
    #1;
  endtask
  // Expected {digit,go,active,done} for an unpaused run with start held, cycle e after start sampled
  function automatic logic [6:0] exp_a(input int e);
    if (e <= 0) return 7'b0000_000;
    if (e <= 4) return {4'd3, 3'b010};
    if (e <= 8) return {4'd2, 3'b010};
    if (e <= 12) return {4'd1, 3'b010};
    if (e <= 14) return {4'd0, 3'b110};
    return {4'd0, 3'b001};
  endfunction
  task automatic idle_gap();
    start_a = 1'b0;
    start_b = 1'b0;
    hold_a  = 1'b0;
    step();
    step();
  endtask
  initial begin
    #2;
    chk("reset_a", out_a, 7'b0);
    chk("reset_b", out_b, 7'b0);
    #6 rst = 1'b0;
    step();
    chk("idle_no_start", out_a, 7'b0);
    // Nominal run
    start_a = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      chk($sformatf("nom_c%0d", c), out_a, exp_a(c));
    end
    start_a = 1'b0;
    step();
    chk("nom_handshake_c21", out_a, 7'b0);
    idle_gap();
    // Pause for 10 sampled edges starting at cycle 6
    start_a = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      step();
      chk($sformatf("pause_c%0d", c), out_a, exp_a(c < 6 ? c : (c < 16 ? 5 : c - 10)));
      if (c == 5) hold_a = 1'b1;
      if (c == 15) hold_a = 1'b0;
    end
    idle_gap();
    // Abort while digit=2
    start_a = 1'b1;
    for (int c = 1; c <= 7; c++) step();
    chk("abort_c7", out_a, {4'd2, 3'b010});
    start_a = 1'b0;
    step();
    chk("abort_c8", out_a, 7'b0);
    for (int c = 9; c <= 18; c++) begin
      step();
      chk($sformatf("abort_quiet_c%0d", c), out_a, 7'b0);
    end
    // Async reset during GO, start kept high
    start_a = 1'b1;
    for (int c = 1; c <= 13; c++) step();
    chk("rst_pre_go", out_a, {4'd0, 3'b110});
    #2 rst = 1'b1;
    #1 chk("rst_async_clear", out_a, 7'b0);
    #2 rst = 1'b0;
    step();
    chk("rst_restart_c1", out_a, {4'd3, 3'b010});
    step();
    chk("rst_restart_c2", out_a, {4'd3, 3'b010});
    idle_gap();
    // Abort on the same edge as the final digit's terminal tick
    start_a = 1'b1;
    for (int c = 1; c <= 12; c++) step();
    chk("coll_c12", out_a, {4'd1, 3'b010});
    start_a = 1'b0;
    for (int c = 13; c <= 16; c++) begin
      step();
      chk($sformatf("coll_c%0d", c), out_a, 7'b0);
    end
    // STEPS=1, TICKS_PER_STEP=2, GO_TICKS=1
    start_b = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("b_c%0d", c), out_b, c <= 2 ? {4'd1, 3'b010} : (c == 3 ? {4'd0, 3'b110} : {4'd0, 3'b001}));
    end
    start_b = 1'b0;
    step();
    chk("b_handshake", out_b, 7'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
